// File: rtl/vi_srgb_tx_pkg.sv
// Shared definitions for the serial-RGB transmitter: FSM states, pixel record,
// sync-word layout and the constants substituted when the port idles or underruns.
package vi_srgb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_RED  = 3'd2,
    ST_GRN  = 3'd3,
    ST_BLU  = 3'd4
  } state_t;

  // All syncs inactive (high on the wire), colour bits zero.
  localparam logic [6:0] SRGB_IDLE_WORD = 7'h0F;

  // Bit positions of the active-low flags inside the sync word.
  localparam int SW_VSYNC_BIT = 0;
  localparam int SW_CSYNC_BIT = 1;
  localparam int SW_HSYNC_BIT = 2;
  localparam int SW_CLAMP_BIT = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       vsync;
    logic       hsync;
    logic       csync;
    logic       clamp;
  } pixel_t;

  localparam pixel_t BLANK_PIXEL = pixel_t'('0);

  function automatic logic [6:0] sync_word(input pixel_t p);
    logic [6:0] w;
    w               = '0;
    w[SW_VSYNC_BIT] = ~p.vsync;
    w[SW_CSYNC_BIT] = ~p.csync;
    w[SW_HSYNC_BIT] = ~p.hsync;
    w[SW_CLAMP_BIT] = ~p.clamp;
    return w;
  endfunction

endpackage

// File: rtl/vi_srgb_tx_if.sv
// Pixel handshake between the VI pixel pipeline (master) and the SRGB transmitter (slave).
interface vi_srgb_tx_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       pix_vsync;
  logic       pix_hsync;
  logic       pix_csync;
  logic       pix_clamp;

  modport master (
    output pix_valid, pix_r, pix_g, pix_b,
    output pix_vsync, pix_hsync, pix_csync, pix_clamp,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_r, pix_g, pix_b,
    input  pix_vsync, pix_hsync, pix_csync, pix_clamp,
    output pix_ready
  );
endinterface

// File: rtl/vi_srgb_reduce.sv
// 8-to-7 bit colour reduction: truncation, or round-half-up saturating at 127.
module vi_srgb_reduce #(
  parameter bit ROUND = 1'b0
) (
  input  logic [7:0] c,
  output logic [6:0] y
);
  logic [8:0] sum;
  logic [7:0] half;
  logic       unused_lsb;

  // The 9-bit sum keeps 255+1 from wrapping; its top bit flags the saturating case.
  assign sum        = {1'b0, c} + (ROUND ? 9'd1 : 9'd0);
  assign half       = sum[8:1];
  assign unused_lsb = sum[0];
  assign y          = half[7] ? 7'h7F : half[6:0];

endmodule

// File: rtl/vi_srgb_tx.sv
// Serial-RGB transmitter: one pixel per handshake, sent as sync, red, green and blue
// words on the 7-bit SRGB port, with blank-pixel substitution on underrun.
module vi_srgb_tx
  import vi_srgb_tx_pkg::*;
#(
  parameter bit ROUND = 1'b0
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        en,
  vi_srgb_tx_if.slave pix,
  output logic [6:0]  srgb,
  output logic        tsyncb,
  output logic        underrun,
  output logic [7:0]  underrun_cnt,
  input  logic        underrun_clr
);

  state_t     state_reg, state_next;
  pixel_t     cap_reg, cap_next;
  pixel_t     in_pix;
  logic       boundary;
  logic       ready;
  logic       accept;
  logic       underrun_ev;
  logic [7:0] comp_sel;
  logic [6:0] comp_word;
  logic [6:0] srgb_reg, srgb_next;
  logic       tsyncb_reg, tsyncb_next;
  logic       underrun_reg, underrun_next;
  logic [7:0] cnt_reg, cnt_next;

  // A new pixel may only start from IDLE or on the last word of the current one.
  // Gating with reset_l holds pix_ready low for the whole reset interval.
  assign boundary      = (state_reg == ST_IDLE) || (state_reg == ST_BLU);
  assign ready         = reset_l & en & boundary;
  assign accept        = ready & pix.pix_valid;
  assign underrun_ev   = en & (state_reg == ST_BLU) & ~pix.pix_valid;
  assign pix.pix_ready = ready;

  assign in_pix = '{r:     pix.pix_r,
                    g:     pix.pix_g,
                    b:     pix.pix_b,
                    vsync: pix.pix_vsync,
                    hsync: pix.pix_hsync,
                    csync: pix.pix_csync,
                    clamp: pix.pix_clamp};

  always_comb begin
    state_next = state_reg;
    cap_next   = cap_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SYNC;
          cap_next   = in_pix;
        end
      end
      ST_SYNC: state_next = ST_RED;
      ST_RED:  state_next = ST_GRN;
      ST_GRN:  state_next = ST_BLU;
      ST_BLU: begin
        if (accept) begin
          state_next = ST_SYNC;
          cap_next   = in_pix;
        end else if (underrun_ev) begin
          state_next = ST_SYNC;
          cap_next   = BLANK_PIXEL;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One shared reducer, fed with whichever component the current state emits.
  always_comb begin
    comp_sel = cap_reg.b;
    case (state_reg)
      ST_RED:  comp_sel = cap_reg.r;
      ST_GRN:  comp_sel = cap_reg.g;
      default: comp_sel = cap_reg.b;
    endcase
  end

  vi_srgb_reduce #(
    .ROUND(ROUND)
  ) u_reduce (
    .c(comp_sel),
    .y(comp_word)
  );

  // The output word trails the state by one clock, so a pixel accepted at edge t
  // shows its sync word after edge t+1.
  always_comb begin
    srgb_next   = SRGB_IDLE_WORD;
    tsyncb_next = (state_reg != ST_SYNC);
    case (state_reg)
      ST_SYNC:                 srgb_next = sync_word(cap_reg);
      ST_RED, ST_GRN, ST_BLU:  srgb_next = comp_word;
      default:                 srgb_next = SRGB_IDLE_WORD;
    endcase
  end

  // A new underrun beats a simultaneous clear so the event is never lost.
  always_comb begin
    underrun_next = underrun_reg;
    cnt_next      = cnt_reg;
    if (underrun_ev) begin
      underrun_next = 1'b1;
      if (underrun_clr) begin
        cnt_next = 8'd1;
      end else if (cnt_reg != 8'hFF) begin
        cnt_next = cnt_reg + 8'd1;
      end
    end else if (underrun_clr) begin
      underrun_next = 1'b0;
      cnt_next      = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg    <= ST_IDLE;
      cap_reg      <= BLANK_PIXEL;
      srgb_reg     <= SRGB_IDLE_WORD;
      tsyncb_reg   <= 1'b1;
      underrun_reg <= 1'b0;
      cnt_reg      <= 8'd0;
    end else begin
      state_reg    <= state_next;
      cap_reg      <= cap_next;
      srgb_reg     <= srgb_next;
      tsyncb_reg   <= tsyncb_next;
      underrun_reg <= underrun_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign srgb         = srgb_reg;
  assign tsyncb       = tsyncb_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = cnt_reg;

endmodule

// File: tb/tb_vi_srgb_tx.sv
// Randomised self-checking bench for vi_srgb_tx: a truncating and a rounding instance
// share one stimulus and are compared each cycle against a word-queue model.
module tb_vi_srgb_tx;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       en = 1'b0;
  logic       pix_valid = 1'b0;
  logic       underrun_clr = 1'b0;
  logic [7:0] pr = 8'd0, pg = 8'd0, pb = 8'd0;
  logic       pvs = 1'b0, phs = 1'b0, pcs = 1'b0, pcl = 1'b0;

  logic [6:0] srgb0, srgb1;
  logic       tsyncb0, tsyncb1, und0, und1;
  logic [7:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  vi_srgb_tx_if if0 ();
  vi_srgb_tx_if if1 ();

  assign if0.pix_valid = pix_valid;
  assign if0.pix_r     = pr;
  assign if0.pix_g     = pg;
  assign if0.pix_b     = pb;
  assign if0.pix_vsync = pvs;
  assign if0.pix_hsync = phs;
  assign if0.pix_csync = pcs;
  assign if0.pix_clamp = pcl;
  assign if1.pix_valid = pix_valid;
  assign if1.pix_r     = pr;
  assign if1.pix_g     = pg;
  assign if1.pix_b     = pb;
  assign if1.pix_vsync = pvs;
  assign if1.pix_hsync = phs;
  assign if1.pix_csync = pcs;
  assign if1.pix_clamp = pcl;

  vi_srgb_tx #(.ROUND(1'b0)) dut0 (
    .clk(clk), .reset_l(reset_l), .en(en), .pix(if0),
    .srgb(srgb0), .tsyncb(tsyncb0), .underrun(und0),
    .underrun_cnt(cnt0), .underrun_clr(underrun_clr)
  );

  vi_srgb_tx #(.ROUND(1'b1)) dut1 (
    .clk(clk), .reset_l(reset_l), .en(en), .pix(if1),
    .srgb(srgb1), .tsyncb(tsyncb1), .underrun(und1),
    .underrun_cnt(cnt1), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  // Reference model: every started pixel schedules four words on a queue; the port
  // emits one queued word per clock, or the idle word when nothing is queued.
  typedef struct {
    logic       first;
    logic [6:0] w0;
    logic [6:0] w1;
  } slot_t;

  slot_t      m_q[$];
  logic [6:0] m_srgb0 = 7'h0F;
  logic [6:0] m_srgb1 = 7'h0F;
  logic       m_tsyncb = 1'b1;
  logic       m_und = 1'b0;
  int         m_cnt = 0;
  int         m_acc = 0;
  int         m_und_total = 0;
  bit         m_und_last = 1'b0;

  logic [33:0] obs_vec;
  assign obs_vec = {srgb0, srgb1, tsyncb0, tsyncb1, und0, und1, cnt0, cnt1};
  logic [1:0] obs_rdy;
  assign obs_rdy = {if0.pix_ready, if1.pix_ready};

  function automatic logic [6:0] red_trunc(input logic [7:0] c);
    int v;
    v = int'(c) / 2;
    return 7'(v);
  endfunction

  function automatic logic [6:0] red_round(input logic [7:0] c);
    int v;
    v = (int'(c) + 1) / 2;
    if (v > 127) v = 127;
    return 7'(v);
  endfunction

  function automatic void push_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                     input logic vs, input logic hs, input logic cs, input logic cl);
    slot_t s;
    s.first = 1'b1;
    s.w0 = {3'b000, ~cl, ~hs, ~cs, ~vs};
    s.w1 = s.w0;
    m_q.push_back(s);
    s.first = 1'b0;
    s.w0 = red_trunc(r); s.w1 = red_round(r); m_q.push_back(s);
    s.w0 = red_trunc(g); s.w1 = red_round(g); m_q.push_back(s);
    s.w0 = red_trunc(b); s.w1 = red_round(b); m_q.push_back(s);
  endfunction

  function automatic logic [33:0] exp_vec();
    return {m_srgb0, m_srgb1, m_tsyncb, m_tsyncb, m_und, m_und, 8'(m_cnt), 8'(m_cnt)};
  endfunction

  function automatic bit m_ready();
    return reset_l && en && (m_q.size() <= 1);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_srgb0 = 7'h0F; m_srgb1 = 7'h0F; m_tsyncb = 1'b1;
    m_und = 1'b0; m_cnt = 0; m_und_last = 1'b0;
  endtask

  task automatic model_step();
    bit    rdy, und_ev;
    slot_t e;
    rdy    = en && (m_q.size() <= 1);
    und_ev = rdy && !pix_valid && (m_q.size() == 1);
    if (m_q.size() != 0) begin
      e = m_q.pop_front();
      m_srgb0 = e.w0; m_srgb1 = e.w1; m_tsyncb = !e.first;
    end else begin
      m_srgb0 = 7'h0F; m_srgb1 = 7'h0F; m_tsyncb = 1'b1;
    end
    if (rdy && pix_valid) begin
      push_pixel(pr, pg, pb, pvs, phs, pcs, pcl);
      m_acc++;
      $display("pixel %0d accepted: r=%02h g=%02h b=%02h v=%0b h=%0b c=%0b k=%0b",
               m_acc, pr, pg, pb, pvs, phs, pcs, pcl);
    end else if (und_ev) begin
      push_pixel(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      m_und_total++;
      $display("underrun %0d: blank pixel substituted", m_und_total);
    end
    m_und_last = und_ev;
    if (und_ev) begin
      m_und = 1'b1;
      if (underrun_clr) m_cnt = 1;
      else if (m_cnt < 255) m_cnt++;
    end else if (underrun_clr) begin
      m_und = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_l = 1'b0; en = 1'b1; pix_valid = 1'b1; pr = 8'hAA;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (srgb0 !== 7'h0F || srgb1 !== 7'h0F) begin
      n_errors++; $display("FAIL reset_srgb: got %h/%h expected 0f", srgb0, srgb1);
    end
    n_checks++;
    if (tsyncb0 !== 1'b1 || tsyncb1 !== 1'b1) begin
      n_errors++; $display("FAIL reset_tsyncb: got %b/%b expected 1", tsyncb0, tsyncb1);
    end
    n_checks++;
    if (obs_rdy !== 2'b00) begin
      n_errors++; $display("FAIL reset_ready: got %b expected 00", obs_rdy);
    end
    n_checks++;
    if (und0 !== 1'b0 || und1 !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      n_errors++; $display("FAIL reset_underrun: got %b/%b cnt %0d/%0d expected 0", und0, und1, cnt0, cnt1);
    end
    en = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
    model_reset();
  endtask

  task automatic test_single_pixel();
    logic [6:0] tab [5];
    tab = '{7'h0B, 7'h40, 7'h20, 7'h7F, 7'h0F};
    en = 1'b1; pix_valid = 1'b1; pr = 8'h80; pg = 8'h41; pb = 8'hFF;
    pvs = 1'b0; phs = 1'b1; pcs = 1'b0; pcl = 1'b0;
    #1;
    n_checks++;
    if (obs_rdy !== 2'b11 || obs_rdy !== {2{m_ready()}}) begin
      n_errors++; $display("FAIL single_ready: got %b expected 11", obs_rdy);
    end
    cycle();
    en = 1'b0; pix_valid = 1'b0; phs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++; $display("FAIL single_model word %0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      n_checks++;
      if (srgb0 !== tab[i] || tsyncb0 !== (i != 0)) begin
        n_errors++; $display("FAIL single_word %0d: got %h tsyncb %b expected %h tsyncb %b",
                             i, srgb0, tsyncb0, tab[i], (i != 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, syncs, last_sync;
    base = m_acc; syncs = 0; last_sync = -1;
    en = 1'b1; pix_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_acc - base >= 16) begin
        en = 1'b0; pix_valid = 1'b0;
      end else begin
        pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
        pvs = 1'($urandom); phs = 1'($urandom); pcs = 1'($urandom); pcl = 1'($urandom);
      end
      #1;
      n_checks++;
      if (obs_rdy !== {2{m_ready()}}) begin
        n_errors++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", i, obs_rdy, {2{m_ready()}});
      end
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++; $display("FAIL b2b_model cycle %0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (tsyncb0 === 1'b0) begin
        if (last_sync >= 0) begin
          n_checks++;
          if (i - last_sync != 4) begin
            n_errors++; $display("FAIL b2b_gap: got %0d cycles between syncs expected 4", i - last_sync);
          end
        end
        last_sync = i;
        syncs++;
      end
    end
    n_checks++;
    if (syncs != 16 || und0 !== 1'b0) begin
      n_errors++; $display("FAIL b2b_count: got %0d syncs underrun %b expected 16 syncs underrun 0", syncs, und0);
    end
  endtask

  task automatic test_underrun();
    int         base, k;
    bit         dropped;
    logic [6:0] tab [4];
    tab = '{7'h0F, 7'h00, 7'h00, 7'h00};
    en = 1'b0; pix_valid = 1'b0; underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    base = m_acc; dropped = 1'b0; k = -1; en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!dropped && (m_acc - base == 1) && (m_q.size() == 1)) begin
        pix_valid = 1'b0; dropped = 1'b1;
      end else if (m_acc - base >= 2) begin
        pix_valid = 1'b0; en = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
        pvs = 1'($urandom); phs = 1'($urandom); pcs = 1'($urandom); pcl = 1'($urandom);
      end
      #1;
      n_checks++;
      if (obs_rdy !== {2{m_ready()}}) begin
        n_errors++; $display("FAIL urun_ready cycle %0d: got %b expected %b", i, obs_rdy, {2{m_ready()}});
      end
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++; $display("FAIL urun_model cycle %0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (k >= 0 && k < 4) begin
        n_checks++;
        if (srgb0 !== tab[k] || srgb1 !== tab[k]) begin
          n_errors++; $display("FAIL urun_blank word %0d: got %h/%h expected %h", k, srgb0, srgb1, tab[k]);
        end
        k++;
      end
      if (m_und_last) k = 0;
    end
    n_checks++;
    if (und0 !== 1'b1 || cnt0 !== 8'd1 || cnt1 !== 8'd1 || k != 4) begin
      n_errors++; $display("FAIL urun_flag: got underrun %b cnt %0d/%0d blank words %0d expected 1 1 4",
                           und0, cnt0, cnt1, k);
    end
  endtask

  task automatic test_saturation();
    int base, start_acc;
    base = m_und_total; start_acc = m_acc;
    en = 1'b1;
    pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
    for (int i = 0; i < 1400 && (m_und_total - base) < 300; i++) begin
      pix_valid = (m_acc == start_acc);
      #1;
      n_checks++;
      if (obs_rdy !== {2{m_ready()}}) begin
        n_errors++; $display("FAIL sat_ready cycle %0d: got %b expected %b", i, obs_rdy, {2{m_ready()}});
      end
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++; $display("FAIL sat_model cycle %0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    n_checks++;
    if (m_und_total - base < 300) begin
      n_errors++; $display("FAIL sat_timeout: got %0d underruns expected 300", m_und_total - base);
    end
    n_checks++;
    if (cnt0 !== 8'd255 || cnt1 !== 8'd255 || und0 !== 1'b1) begin
      n_errors++; $display("FAIL sat_count: got %0d/%0d underrun %b expected 255 1", cnt0, cnt1, und0);
    end
    for (int i = 0; i < 8 && m_q.size() != 1; i++) cycle();
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    n_checks++;
    if (und0 !== 1'b1 || cnt0 !== 8'd1 || cnt1 !== 8'd1) begin
      n_errors++; $display("FAIL clr_vs_set: got underrun %b cnt %0d/%0d expected 1 1", und0, cnt0, cnt1);
    end
    underrun_clr = 1'b1; en = 1'b0;
    cycle();
    underrun_clr = 1'b0;
    n_checks++;
    if (und0 !== 1'b0 || cnt0 !== 8'd0 || und1 !== 1'b0 || cnt1 !== 8'd0) begin
      n_errors++; $display("FAIL clr_only: got underrun %b cnt %0d expected 0 0", und0, cnt0);
    end
    repeat (6) begin
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++; $display("FAIL sat_drain: got %h expected %h", obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_round();
    logic [6:0] t0 [3];
    logic [6:0] t1 [3];
    t0 = '{7'd127, 7'd127, 7'd1};
    t1 = '{7'd127, 7'd127, 7'd2};
    en = 1'b1; pix_valid = 1'b1; pr = 8'd254; pg = 8'd255; pb = 8'd3;
    pvs = 1'($urandom); phs = 1'($urandom); pcs = 1'($urandom); pcl = 1'($urandom);
    #1;
    cycle();
    en = 1'b0; pix_valid = 1'b0;
    for (int k = -1; k < 4; k++) begin
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++; $display("FAIL round_model step %0d: got %h expected %h", k, obs_vec, exp_vec());
      end
      if (k >= 0 && k < 3) begin
        n_checks++;
        if (srgb0 !== t0[k] || srgb1 !== t1[k]) begin
          n_errors++; $display("FAIL round_word %0d: got %0d/%0d expected %0d/%0d",
                               k, srgb0, srgb1, t0[k], t1[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; pix_valid = 1'b1;
    pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
    #1;
    cycle();
    pix_valid = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (obs_vec !== exp_vec()) begin
      n_errors++; $display("FAIL rmid_pre: got %h expected %h", obs_vec, exp_vec());
    end
    #2;
    reset_l = 1'b0;
    #1;
    n_checks++;
    if (srgb0 !== 7'h0F || srgb1 !== 7'h0F || tsyncb0 !== 1'b1 || obs_rdy !== 2'b00) begin
      n_errors++; $display("FAIL rmid_async: got srgb %h tsyncb %b ready %b expected 0f 1 00",
                           srgb0, tsyncb0, obs_rdy);
    end
    model_reset();
    @(negedge clk);
    pix_valid = 1'b1;
    reset_l = 1'b1;
    #1;
    n_checks++;
    if (obs_rdy !== 2'b11 || obs_rdy !== {2{m_ready()}}) begin
      n_errors++; $display("FAIL rmid_ready: got %b expected 11", obs_rdy);
    end
    cycle();
    pix_valid = 1'b0; en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++; $display("FAIL rmid_post cycle %0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (i == 0) begin
        n_checks++;
        if (tsyncb0 !== 1'b0) begin
          n_errors++; $display("FAIL rmid_first_accept: got tsyncb %b expected 0", tsyncb0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_underrun();
    test_saturation();
    test_round();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
